// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the single-port RAM arbiter and the blocks around it
// (RAM instance, CPU front-end and LSU use the same widths).
package ram_arbiter_pkg;

  localparam int RAM_ADDR_W = 10;
  localparam int RAM_DATA_W = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way grant: round-robin on ties, or port 0 always wins
// when FIXED_PRI is set.
module rr_arb2 #(
  parameter int FIXED_PRI = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant
);

  assign grant_valid = req0 | req1;

  always_comb begin
    // NOTE: give grant a default first so every path assigns it and no latch is inferred.
    grant = 1'b0;
    if (req0 && req1) begin
      grant = (FIXED_PRI != 0) ? 1'b0 : ~last_grant;
    end else if (req1) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between instruction fetch (port 0) and the LSU
// (port 1): IDLE -> BUSY (one RAM cycle) -> ACK (one-cycle ack pulse).
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = RAM_ADDR_W,
  parameter int DATA_W    = RAM_DATA_W,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_write,
  output logic              ram_str,
  output logic              ram_ld,
  input  logic [DATA_W-1:0] ram_read
);

  arb_state_t        state;
  logic              owner;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              last_grant;
  logic              grant_valid;
  logic              grant;

  rr_arb2 #(
    .FIXED_PRI(FIXED_PRI)
  ) u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .grant_valid(grant_valid),
    .grant      (grant)
  );

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values
  // regardless of statement order inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      last_grant <= 1'b1;   // port 0 wins the first tie after reset
      owner      <= 1'b0;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner      <= grant;
            cmd_we     <= grant ? we1    : we0;
            cmd_addr   <= grant ? addr1  : addr0;
            cmd_wdata  <= grant ? wdata1 : wdata0;
            last_grant <= grant;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // Read data is captured at the edge closing the RAM cycle; writes leave rdata untouched.
          if (!cmd_we) begin
            if (owner) rdata1 <= ram_read;
            else       rdata0 <= ram_read;
          end
          ack0  <= ~owner;
          ack1  <= owner;
          state <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM pins are driven only during BUSY so an idle bus never strobes or loads.
  always_comb begin
    ram_addr  = '0;
    ram_write = '0;
    ram_str   = 1'b0;
    ram_ld    = 1'b0;
    if (state == BUSY) begin
      ram_addr = cmd_addr;
      ram_str  = cmd_we;
      ram_ld   = ~cmd_we;
      if (cmd_we) ram_write = cmd_wdata;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model (memory array + grant schedule).
module tb_ram_arbiter;

  localparam int AW = 10;
  localparam int DW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin DUT and its RAM
  logic          rst;
  logic [1:0]    req, we;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          ack0_w, ack1_w;
  logic [DW-1:0] rdata0_w, rdata1_w;
  logic [1:0]    ack;
  logic [DW-1:0] rdata [2];
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_write, ram_read;
  logic          ram_str, ram_ld;
  logic [DW-1:0] ram_mem [1024];

  // Fixed-priority DUT with an address-echo RAM
  logic          rst_f, req0_f, req1_f, ack0_f, ack1_f, ram_str_f, ram_ld_f;
  logic [DW-1:0] rdata0_f, rdata1_f, ram_write_f, ram_read_f;
  logic [AW-1:0] ram_addr_f;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRI(0)) dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]), .ack0(ack0_w), .rdata0(rdata0_w),
    .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]), .ack1(ack1_w), .rdata1(rdata1_w),
    .ram_addr(ram_addr), .ram_write(ram_write), .ram_str(ram_str), .ram_ld(ram_ld), .ram_read(ram_read)
  );

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRI(1)) dut_fx (
    .clk(clk), .rst(rst_f),
    .req0(req0_f), .we0(1'b0), .addr0(10'h0AA), .wdata0(20'h0), .ack0(ack0_f), .rdata0(rdata0_f),
    .req1(req1_f), .we1(1'b0), .addr1(10'h155), .wdata1(20'h0), .ack1(ack1_f), .rdata1(rdata1_f),
    .ram_addr(ram_addr_f), .ram_write(ram_write_f), .ram_str(ram_str_f), .ram_ld(ram_ld_f),
    .ram_read(ram_read_f)
  );

  assign ack      = {ack1_w, ack0_w};
  assign rdata[0] = rdata0_w;
  assign rdata[1] = rdata1_w;

  always @(posedge clk) if (ram_str) ram_mem[ram_addr] <= ram_write;
  assign ram_read   = ram_ld ? ram_mem[ram_addr] : 20'h5A5A5;
  assign ram_read_f = ram_ld_f ? {10'd0, ram_addr_f} : 20'h0;

  int total = 0;
  int bad   = 0;

  // Reference model: memory contents, per-port read registers, grant schedule
  logic [DW-1:0] mem_m [1024];
  logic [DW-1:0] exp_rd [2];
  int            cyc = 0, free_edge = 0, g_edge = 0;
  bit            act = 0, last = 1, a_port = 0, a_we = 0;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  bit   [1:0]    m_ack;
  int            m_gnt;

  // Advance one clock edge, predicting its effect and checking every output.
  task automatic cycle();
    int e;
    bit busy;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic es, el;
    e = cyc + 1; busy = 0; m_ack = '0; m_gnt = -1;
    if (act && e == g_edge + 1) begin
      act = 0;
      if (a_we) mem_m[a_addr] = a_data;
      else if (!rst) exp_rd[a_port] = mem_m[a_addr];
      if (!rst) m_ack[a_port] = 1'b1;
    end
    if (rst) begin
      act = 0; last = 1; free_edge = e + 1;
      exp_rd[0] = '0; exp_rd[1] = '0;
    end else if (e >= free_edge && req != 2'b00) begin
      a_port = (req == 2'b11) ? ~last : req[1];
      a_we = we[a_port]; a_addr = addr[a_port]; a_data = wdata[a_port];
      act = 1; g_edge = e; free_edge = e + 3; last = a_port; busy = 1; m_gnt = int'(a_port);
    end
    ea = '0; ew = '0; es = 0; el = 0;
    if (busy) begin
      ea = a_addr; es = a_we; el = ~a_we; ew = a_we ? a_data : '0;
    end
    @(posedge clk); #1;
    cyc = e;
    for (int p = 0; p < 2; p++) begin
      total++;
      if (ack[p] !== m_ack[p]) begin
        bad++; $display("FAIL ack%0d cyc=%0d got=%b want=%b", p, cyc, ack[p], m_ack[p]);
      end
      total++;
      if (rdata[p] !== exp_rd[p]) begin
        bad++; $display("FAIL rdata%0d cyc=%0d got=%h want=%h", p, cyc, rdata[p], exp_rd[p]);
      end
    end
    total++;
    if ({ram_addr, ram_write, ram_str, ram_ld} !== {ea, ew, es, el}) begin
      bad++;
      $display("FAIL ram_pins cyc=%0d got=%h/%h/%b/%b want=%h/%h/%b/%b",
               cyc, ram_addr, ram_write, ram_str, ram_ld, ea, ew, es, el);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // One complete access on port p; fields are scrambled after the grant to prove latching.
  task automatic do_access(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int busy_cyc, output int ack_cyc, output int str_cnt);
    busy_cyc = -1; ack_cyc = -1; str_cnt = 0;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    for (int n = 0; n < 8 && ack_cyc < 0; n++) begin
      cycle();
      if (ram_str === 1'b1) str_cnt++;
      if ((ram_str === 1'b1 || ram_ld === 1'b1) && busy_cyc < 0) busy_cyc = cyc;
      if (ack[p] === 1'b1) ack_cyc = cyc;
      if (m_gnt == p) begin we[p] = ~w; addr[p] = ~a; wdata[p] = ~d; end
    end
    req[p] = 1'b0;
    cycle();
    if (ram_str === 1'b1) str_cnt++;
    total++;
    if (ack_cyc < 0) begin
      bad++; $display("FAIL ack_timeout port%0d got=none want=ack within 8 cycles", p);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; we = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    cycle(); cycle();
    total++;
    if (ack !== 2'b00 || rdata[0] !== '0 || rdata[1] !== '0 || ram_str !== 1'b0 || ram_ld !== 1'b0) begin
      bad++; $display("FAIL reset_state got ack=%b rd0=%h rd1=%h str=%b ld=%b want all zero",
                      ack, rdata[0], rdata[1], ram_str, ram_ld);
    end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_write_read();
    int b, a, s;
    do_access(0, 1'b1, 10'h005, 20'hABCDE, b, a, s);
    total++;
    if (s != 1) begin bad++; $display("FAIL str_cycles got=%0d want=1", s); end
    total++;
    if (a - b != 1) begin bad++; $display("FAIL ack_latency got=%0d want=1", a - b); end
    do_access(0, 1'b0, 10'h005, 20'h0, b, a, s);
    total++;
    if (rdata[0] !== 20'hABCDE || ack[1] !== 1'b0) begin
      bad++; $display("FAIL read_back got=%h ack1=%b want=abcde ack1=0", rdata[0], ack[1]);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    rst = 1'b1; req = 2'b11; we = 2'b00; addr[0] = 10'h020; addr[1] = 10'h021;
    cycle();
    rst = 1'b0;
    for (int round = 0; round < 2; round++) begin
      order.delete();
      req = 2'b11;
      for (int n = 0; n < 12; n++) begin
        cycle();
        for (int p = 0; p < 2; p++) if (ack[p] === 1'b1) begin order.push_back(p); req[p] = 1'b0; end
      end
      total++;
      if (order.size() != 2 || order[0] != 0 || order[1] != 1) begin
        bad++; $display("FAIL rr_order round=%0d got=%p want='{0,1}", round, order);
      end
    end
  endtask

  task automatic test_isolation();
    int b, a, s;
    do_access(1, 1'b0, 10'h005, 20'h0, b, a, s);
    total++;
    if (rdata[1] !== 20'hABCDE) begin bad++; $display("FAIL iso_prior got=%h want=abcde", rdata[1]); end
    do_access(1, 1'b1, 10'h3FF, 20'h12345, b, a, s);
    do_access(0, 1'b0, 10'h3FF, 20'h0, b, a, s);
    total++;
    if (rdata[0] !== 20'h12345 || rdata[1] !== 20'hABCDE) begin
      bad++; $display("FAIL isolation got rd0=%h rd1=%h want rd0=12345 rd1=abcde", rdata[0], rdata[1]);
    end
  endtask

  task automatic test_held_req();
    int first = -1, second = -1;
    idle(2);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 10'h005;
    for (int n = 0; n < 12; n++) begin
      cycle();
      if (ack[1] === 1'b1) begin
        if (first < 0) begin first = cyc; addr[1] = 10'h3FF; end
        else if (second < 0) begin second = cyc; req[1] = 1'b0; end
      end
    end
    total++;
    if (first < 0 || second - first != 3) begin
      bad++; $display("FAIL held_spacing got=%0d want=3", second - first);
    end
    total++;
    if (rdata[1] !== 20'h12345) begin bad++; $display("FAIL held_second_read got=%h want=12345", rdata[1]); end
  endtask

  task automatic test_reset_busy();
    int b, a, s, acks = 0;
    idle(2);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 10'h010; wdata[0] = 20'h00FFF;
    cycle();
    total++;
    if (ram_str !== 1'b1) begin bad++; $display("FAIL rst_busy_str got=%b want=1", ram_str); end
    rst = 1'b1; req[0] = 1'b0;
    cycle();
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      cycle();
      if (ack !== 2'b00) acks++;
    end
    total++;
    if (acks != 0) begin bad++; $display("FAIL rst_busy_ack got=%0d acks want=0", acks); end
    do_access(0, 1'b0, 10'h010, 20'h0, b, a, s);
    total++;
    if (rdata[0] !== 20'h00FFF) begin bad++; $display("FAIL rst_busy_commit got=%h want=00fff", rdata[0]); end
  endtask

  task automatic test_idle_bus();
    req = 2'b00;
    for (int n = 0; n < 20; n++) begin
      cycle();
      total++;
      if (ram_str !== 1'b0 || ram_ld !== 1'b0 || ram_addr !== '0) begin
        bad++; $display("FAIL idle_bus cyc=%0d got str=%b ld=%b addr=%h want 0/0/000",
                        cyc, ram_str, ram_ld, ram_addr);
      end
    end
  endtask

  task automatic test_fixed_pri();
    int prev = -1, n0 = 0;
    rst_f = 1'b1; req0_f = 1'b1; req1_f = 1'b1;
    cycle();
    rst_f = 1'b0;
    for (int n = 0; n < 15; n++) begin
      cycle();
      total++;
      if (ack1_f !== 1'b0 || ram_str_f !== 1'b0 || ram_write_f !== '0) begin
        bad++; $display("FAIL fx_port1 cyc=%0d got ack1=%b str=%b want 0/0", cyc, ack1_f, ram_str_f);
      end
      if (ack0_f === 1'b1) begin
        total++;
        if (prev >= 0 && cyc - prev != 3) begin
          bad++; $display("FAIL fx_spacing got=%0d want=3", cyc - prev);
        end
        total++;
        if (rdata0_f !== 20'h000AA) begin bad++; $display("FAIL fx_rdata got=%h want=000aa", rdata0_f); end
        prev = cyc; n0++;
      end
    end
    total++;
    if (n0 != 5 || rdata1_f !== '0) begin
      bad++; $display("FAIL fx_count got=%0d rd1=%h want=5 rd1=00000", n0, rdata1_f);
    end
    rst_f = 1'b1; req0_f = 1'b0; req1_f = 1'b0;
  endtask

  task automatic new_cmd(input int p);
    req[p]   = 1'b1;
    we[p]    = 1'($urandom_range(1));
    addr[p]  = 10'h3F0 + 10'($urandom_range(15));
    wdata[p] = 20'($urandom_range(20'hFFFFF));
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(79) == 0);
      for (int p = 0; p < 2; p++) if (!req[p] && $urandom_range(2) == 0) new_cmd(p);
      cycle();
      if (m_gnt >= 0) begin
        addr[m_gnt] = 10'($urandom_range(1023)); wdata[m_gnt] = 20'($urandom_range(20'hFFFFF));
      end
      for (int p = 0; p < 2; p++)
        if (m_ack[p]) begin
          if ($urandom_range(1) == 1) new_cmd(p);
          else req[p] = 1'b0;
        end
    end
    rst = 1'b0; req = 2'b00;
    idle(4);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = '0;
      mem_m[i]   = '0;
    end
    exp_rd[0] = '0; exp_rd[1] = '0;
    rst_f = 1'b1; req0_f = 1'b0; req1_f = 1'b0;
    rst = 1'b1; req = '0; we = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_isolation();
    test_held_req();
    test_reset_busy();
    test_idle_bus();
    test_fixed_pri();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
